layer_argmax_8_20: RTL and testbench



---
 rtl/layer_argmax_8_20.sv | 106 ++++++++++
 tb/tb_layer_argmax_8_20.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_argmax_8_20.sv
// Streaming argmax over M signed T-bit words. It accepts one word per s_valid/s_ready beat
// and returns the index and value of the maximum over an m_valid/m_ready handshake.
module layer_argmax_8_20 #(
    parameter int M    = 8,
    parameter int T    = 20,
    parameter int IDXW = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic signed [T-1:0]    data_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [IDXW-1:0]        data_out,
    output logic signed [T-1:0]    max_out
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    localparam logic [IDXW:0] LAST_COUNT = (IDXW+1)'(M - 1);
    localparam logic [IDXW:0] ZERO_COUNT = {(IDXW+1){1'b0}};
    localparam logic [IDXW:0] ONE_COUNT  = {{IDXW{1'b0}}, 1'b1};

    state_t                 state_r;
    logic [IDXW:0]          count_r;
    logic signed [T-1:0]    best_r;
    logic [IDXW-1:0]        best_idx_r;

    logic                   accept_s;
    logic                   last_s;
    logic signed [T-1:0]    next_best_s;
    logic [IDXW-1:0]        next_idx_s;

    // Running-maximum update for the word on the bus; the first word of a vector always seeds it.
    always_comb begin
        accept_s    = s_valid && s_ready;
        last_s      = (count_r == LAST_COUNT);
        next_best_s = best_r;
        next_idx_s  = best_idx_r;
        if (count_r == ZERO_COUNT) begin
            next_best_s = data_in;
            next_idx_s  = {IDXW{1'b0}};
        end else if (data_in > best_r) begin
            next_best_s = data_in;
            next_idx_s  = count_r[IDXW-1:0];
        end else begin
            next_best_s = best_r;
            next_idx_s  = best_idx_r;
        end
    end

    // Collect/output FSM with all outputs registered; s_ready is the complement of m_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= COLLECT;
            count_r    <= ZERO_COUNT;
            best_r     <= {T{1'b0}};
            best_idx_r <= {IDXW{1'b0}};
            s_ready    <= 1'b1;
            m_valid    <= 1'b0;
            data_out   <= {IDXW{1'b0}};
            max_out    <= {T{1'b0}};
        end else begin
            case (state_r)
                COLLECT: begin
                    if (accept_s) begin
                        best_r     <= next_best_s;
                        best_idx_r <= next_idx_s;
                        if (last_s) begin
                            data_out <= next_idx_s;
                            max_out  <= next_best_s;
                            m_valid  <= 1'b1;
                            s_ready  <= 1'b0;
                            count_r  <= ZERO_COUNT;
                            state_r  <= OUTPUT;
                        end else begin
                            count_r  <= count_r + ONE_COUNT;
                        end
                    end else begin
                        count_r <= count_r;
                    end
                end
                OUTPUT: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state_r <= COLLECT;
                    end else begin
                        m_valid <= m_valid;
                    end
                end
                default: begin
                    state_r <= COLLECT;
                    count_r <= ZERO_COUNT;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_argmax_8_20.sv
// Directed and randomised checks of layer_argmax_8_20 against hand-computed expectations
// and a small argmax scoreboard.
module tb_layer_argmax_8_20;

    localparam int M = 8;
    localparam int T = 20;
    localparam int IDXW = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                s_valid = 1'b0;
    logic                s_ready;
    logic signed [T-1:0] data_in = '0;
    logic                m_valid;
    logic                m_ready = 1'b0;
    logic [IDXW-1:0]     data_out;
    logic signed [T-1:0] max_out;

    int n_vec = 0;
    int n_bad = 0;

    typedef logic signed [T-1:0] word_t;
    typedef word_t vec_t [M];

    layer_argmax_8_20 #(.M(M), .T(T), .IDXW(IDXW)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .data_in(data_in), .m_valid(m_valid), .m_ready(m_ready),
        .data_out(data_out), .max_out(max_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until it is accepted; returns with time #1 past the accepting edge.
    task automatic send_word(input word_t w);
        int budget;
        logic was_ready;
        budget = 0;
        s_valid = 1'b1;
        data_in = w;
        do begin
            was_ready = s_ready;
            tick();
            budget++;
        end while (!was_ready && budget < 2000);
        if (!was_ready) begin
            n_vec++; n_bad++;
            $display("FAIL send_word_timeout: s_ready stuck at %0b, required 1", s_ready);
        end
        s_valid = 1'b0;
    endtask

    task automatic send_vec(input vec_t v);
        for (int i = 0; i < M; i++) send_word(v[i]);
    endtask

    // Wait for m_valid, check the result, then complete the handshake.
    task automatic expect_result(input string name, input logic [IDXW-1:0] e_idx, input word_t e_max);
        int budget;
        budget = 0;
        while (m_valid !== 1'b1 && budget < 200) begin
            tick();
            budget++;
        end
        n_vec++;
        if (m_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_valid: m_valid=%0b, required 1", name, m_valid);
        end
        n_vec++;
        if (data_out !== e_idx) begin
            n_bad++;
            $display("FAIL %s_idx: data_out=%0d, required %0d", name, data_out, e_idx);
        end
        n_vec++;
        if (max_out !== e_max) begin
            n_bad++;
            $display("FAIL %s_max: max_out=%0d, required %0d", name, max_out, e_max);
        end
        m_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_vec++;
        if ({s_ready, m_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_hs: s_ready/m_valid=%b, required 10", {s_ready, m_valid});
        end
        n_vec++;
        if (data_out !== 3'd0 || max_out !== 20'sd0) begin
            n_bad++;
            $display("FAIL reset_out: data_out=%0d max_out=%0d, required 0 0", data_out, max_out);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_tie();
        vec_t v;
        v = '{20'sd5, -20'sd3, 20'sd12, 20'sd7, 20'sd12, 20'sd0, 20'sd1, 20'sd2};
        m_ready = 1'b1;
        send_vec(v);
        n_vec++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL tie_latency: m_valid=%0b s_ready=%0b, required 1 0", m_valid, s_ready);
        end
        n_vec++;
        if (data_out !== 3'd2 || max_out !== 20'sd12) begin
            n_bad++;
            $display("FAIL tie_result: idx=%0d max=%0d, required 2 12", data_out, max_out);
        end
        tick();
        n_vec++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL tie_release: m_valid=%0b s_ready=%0b, required 0 1", m_valid, s_ready);
        end
    endtask

    task automatic test_all_negative();
        vec_t v;
        v = '{-20'sd10, -20'sd4, -20'sd7, -20'sd524288, -20'sd5, -20'sd9, -20'sd4, -20'sd100};
        m_ready = 1'b0;
        send_vec(v);
        expect_result("neg", 3'd1, -20'sd4);
    endtask

    task automatic test_extremes();
        vec_t v;
        v = '{20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd524287};
        m_ready = 1'b0;
        send_vec(v);
        expect_result("last_pos", 3'd7, 20'sd524287);
        v = '{20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0, 20'sd0};
        m_ready = 1'b0;
        send_vec(v);
        expect_result("zeros", 3'd0, 20'sd0);
    endtask

    task automatic test_backpressure();
        vec_t v;
        v = '{20'sd3, 20'sd9, 20'sd1, -20'sd2, 20'sd9, 20'sd4, 20'sd0, 20'sd8};
        m_ready = 1'b0;
        send_vec(v);
        for (int c = 0; c < 5; c++) begin
            s_valid = 1'b1;
            data_in = 20'sd400000 + word_t'(c);
            tick();
            n_vec++;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || data_out !== 3'd1 || max_out !== 20'sd9) begin
                n_bad++;
                $display("FAIL bp_hold: m_valid=%0b s_ready=%0b idx=%0d max=%0d, required 1 0 1 9",
                         m_valid, s_ready, data_out, max_out);
            end
        end
        s_valid = 1'b0;
        expect_result("bp_release", 3'd1, 20'sd9);
        v = '{20'sd1, 20'sd2, 20'sd3, 20'sd4, 20'sd5, 20'sd6, 20'sd7, 20'sd8};
        m_ready = 1'b0;
        send_vec(v);
        expect_result("bp_next", 3'd7, 20'sd8);
    endtask

    task automatic test_reset_mid();
        vec_t v;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_word(20'sd100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_state: s_ready=%0b m_valid=%0b, required 1 0", s_ready, m_valid);
        end
        v = '{20'sd1, 20'sd2, 20'sd3, 20'sd4, 20'sd9, 20'sd5, 20'sd6, 20'sd7};
        send_vec(v);
        expect_result("rstmid", 3'd4, 20'sd9);
        for (int c = 0; c < 10; c++) begin
            n_vec++;
            if (m_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_extra: m_valid=%0b, required 0", m_valid);
            end
            tick();
        end
    endtask

    // Reset in the same cycle as a result handshake must suppress nothing but also produce nothing extra.
    task automatic test_reset_vs_handshake();
        vec_t v;
        v = '{20'sd1, 20'sd1, 20'sd1, 20'sd1, 20'sd1, 20'sd1, 20'sd1, 20'sd1};
        m_ready = 1'b0;
        send_vec(v);
        m_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || data_out !== 3'd0 || max_out !== 20'sd0) begin
            n_bad++;
            $display("FAIL rst_hs: m_valid=%0b s_ready=%0b idx=%0d max=%0d, required 0 1 0 0",
                     m_valid, s_ready, data_out, max_out);
        end
    endtask

    task automatic test_soak();
        logic [IDXW-1:0] q_idx[$];
        word_t           q_max[$];
        int              got;
        got = 0;
        fork
            begin : producer
                vec_t v;
                word_t bmax;
                logic [IDXW-1:0] bidx;
                for (int n = 0; n < 200; n++) begin
                    for (int i = 0; i < M; i++) begin
                        if ($urandom_range(0, 1) == 0)
                            v[i] = word_t'($urandom_range(0, 7)) - 20'sd4;
                        else
                            v[i] = word_t'($urandom);
                    end
                    bmax = v[0];
                    bidx = 3'd0;
                    for (int i = 1; i < M; i++) begin
                        if (v[i] > bmax) begin
                            bmax = v[i];
                            bidx = IDXW'(i);
                        end
                    end
                    q_idx.push_back(bidx);
                    q_max.push_back(bmax);
                    for (int i = 0; i < M; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            s_valid = 1'b0;
                            repeat ($urandom_range(1, 3)) tick();
                        end
                        send_word(v[i]);
                    end
                end
            end
            begin : consumer
                int cyc;
                cyc = 0;
                while (got < 200 && cyc < 40000) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    n_vec++;
                    if (s_ready === m_valid) begin
                        n_bad++;
                        $display("FAIL soak_ready: s_ready=%0b m_valid=%0b, required complementary", s_ready, m_valid);
                    end
                    if (m_valid === 1'b1 && m_ready) begin
                        n_vec++;
                        if (q_idx.size() == 0) begin
                            n_bad++;
                            $display("FAIL soak_extra: result idx=%0d with no vector pending, required none", data_out);
                        end else begin
                            if (data_out !== q_idx[0] || max_out !== q_max[0]) begin
                                n_bad++;
                                $display("FAIL soak_result %0d: idx=%0d max=%0d, required %0d %0d",
                                         got, data_out, max_out, q_idx[0], q_max[0]);
                            end
                            void'(q_idx.pop_front());
                            void'(q_max.pop_front());
                        end
                        got++;
                    end
                    tick();
                    cyc++;
                end
            end
        join
        n_vec++;
        if (got != 200 || q_idx.size() != 0) begin
            n_bad++;
            $display("FAIL soak_count: results=%0d pending=%0d, required 200 0", got, q_idx.size());
        end
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tie();
        test_all_negative();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_reset_vs_handshake();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
